// File: rtl/pc_fetch_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_gen_if
//  Description : Control/bus bundle between the pipeline control logic and
//                the IF-stage program-counter generator.
//                master : pipeline control / instruction-memory side (drives
//                         stall, redirects, ready; observes fetch address)
//                slave  : pc_fetch_gen itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);

  // Pipeline control inputs towards the PC generator
  logic [STALL_W-1:0] stall;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_i;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               if_ready_i;

  // Fetch outputs from the PC generator
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               if_req_o;
  logic               pend_valid_o;
  logic               pc_misalign_o;

  modport master (
    output stall, branch_flag_i, branch_target_i, flush, new_pc, if_ready_i,
    input  pc, ce, if_req_o, pend_valid_o, pc_misalign_o
  );

  modport slave (
    input  stall, branch_flag_i, branch_target_i, flush, new_pc, if_ready_i,
    output pc, ce, if_req_o, pend_valid_o, pc_misalign_o
  );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_gen
//  Description : IF-stage program-counter generator. Produces the registered
//                fetch address and chip enable, steps by STEP bytes, applies
//                flush and branch redirects, and holds on stall[0] or memory
//                back-pressure. A branch that arrives while the PC cannot
//                advance is parked in a one-entry pending-redirect register.
//  Config macro: PC_MISALIGN_CHK_EN
//                defined   -> redirect targets load unmodified and
//                             pc_misalign_o reports |pc[1:0]
//                undefined -> redirect targets are word-aligned before load
//                             and pc_misalign_o is tied low
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_gen #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter int          STEP         = 4,
  parameter int          STALL_W      = 6
) (
  input  wire            clk,
  input  wire            rst,
  pc_fetch_gen_if.slave  bus
);

  localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] c_STEP     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] c_LOW_MASK = ADDR_W'(3);

  typedef enum logic [0:0] {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              r_pend_valid;
  logic              w_pend_valid_next;
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] w_pend_target_next;
  logic              w_ce;
  logic              w_advance;
  logic              w_unused_stall;

  // Only the IF bit of the stall vector matters; the rest is folded away.
  assign w_unused_stall = ^bus.stall;

  // Redirect targets either pass through or are forced word-aligned.
  function automatic logic [ADDR_W-1:0] f_align(input logic [ADDR_W-1:0] a);
`ifdef PC_MISALIGN_CHK_EN
    f_align = a;
`else
    f_align = a & ~c_LOW_MASK;
`endif
  endfunction

  // Chip enable is a pure decode of the state register, so it is glitch-free.
  assign w_ce      = (r_state == ST_RUN);
  assign w_advance = w_ce & ~bus.stall[0] & bus.if_ready_i;

  // State register: reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, next-pc and pending-redirect selection in priority order.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_pend_valid_next  = r_pend_valid;
    w_pend_target_next = r_pend_target;
    case (r_state)
      ST_RESET: begin
        // First non-reset edge enables fetch; pc stays on the vector so the
        // first fetched address is the reset vector itself.
        w_state_next      = ST_RUN;
        w_pc_next         = c_RESET_PC;
        w_pend_valid_next = 1'b0;
      end
      ST_RUN: begin
        if (bus.flush) begin
          w_pc_next         = f_align(bus.new_pc);
          w_pend_valid_next = 1'b0;
        end else if (w_advance && bus.branch_flag_i) begin
          // A fresh branch supersedes any older parked redirect.
          w_pc_next         = f_align(bus.branch_target_i);
          w_pend_valid_next = 1'b0;
        end else if (w_advance && r_pend_valid) begin
          // Parked target was already aligned when it was captured.
          w_pc_next         = r_pend_target;
          w_pend_valid_next = 1'b0;
        end else if (w_advance) begin
          w_pc_next = r_pc + c_STEP;
        end else if (bus.branch_flag_i) begin
          // PC frozen: park the redirect, newest one wins.
          w_pend_target_next = f_align(bus.branch_target_i);
          w_pend_valid_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RESET;
      end
    endcase
  end

  // PC and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= c_RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_target <= w_pend_target_next;
    end
  end

`ifdef PC_MISALIGN_CHK_EN
  generate
    if (1) begin : g_misalign
      logic r_misalign;

      // Misalign flag tracks the pc register edge-for-edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_misalign <= 1'b0;
        end else begin
          r_misalign <= |w_pc_next[1:0];
        end
      end

      assign bus.pc_misalign_o = r_misalign;
    end
  endgenerate
`else
  assign bus.pc_misalign_o = 1'b0;
`endif

  assign bus.pc           = r_pc;
  assign bus.ce           = w_ce;
  assign bus.pend_valid_o = r_pend_valid;
  // Request depends only on registered ce and stall, never on if_ready_i.
  assign bus.if_req_o     = w_ce & ~bus.stall[0];

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_gen
//  Description : Scoreboard bench for pc_fetch_gen. The stimulus process sets
//                each cycle's inputs and queues the outputs expected in that
//                cycle; a monitor pops and compares on every falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_gen;

  localparam logic [31:0] c_R = 32'hBFC0_0000;
`ifdef PC_MISALIGN_CHK_EN
  localparam logic [31:0] c_M   = 32'h8000_0102;
  localparam logic        c_MIS = 1'b1;
`else
  localparam logic [31:0] c_M   = 32'h8000_0100;
  localparam logic        c_MIS = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
    logic        req;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  pc_fetch_gen_if #(.ADDR_W(32), .STALL_W(6)) bus ();

  pc_fetch_gen #(
    .ADDR_W(32), .RESET_VECTOR(32'hBFC0_0000), .STEP(4), .STALL_W(6)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", nm, got, want);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, ".pc"},   bus.pc,                    e.pc);
      chk({e.nm, ".ce"},   {31'd0, bus.ce},            {31'd0, e.ce});
      chk({e.nm, ".pend"}, {31'd0, bus.pend_valid_o},  {31'd0, e.pend});
      chk({e.nm, ".mis"},  {31'd0, bus.pc_misalign_o}, {31'd0, e.mis});
      chk({e.nm, ".req"},  {31'd0, bus.if_req_o},      {31'd0, e.req});
    end
  end

  // One cycle: apply inputs, queue expected outputs for this cycle, then
  // step past the rising edge.
  task automatic cyc(input string nm, input logic r, input logic s,
                     input logic bf, input logic [31:0] bt,
                     input logic fl, input logic [31:0] np, input logic rdy,
                     input logic [31:0] e_pc, input logic e_ce,
                     input logic e_pend, input logic e_mis);
    exp_t e;
    rst                 = r;
    bus.stall           = {5'b0, s};
    bus.branch_flag_i   = bf;
    bus.branch_target_i = bt;
    bus.flush           = fl;
    bus.new_pc          = np;
    bus.if_ready_i      = rdy;
    e.nm = nm; e.pc = e_pc; e.ce = e_ce; e.pend = e_pend; e.mis = e_mis;
    e.req = e_ce & ~s;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall = '0; bus.branch_flag_i = 1'b0; bus.branch_target_i = '0;
    bus.flush = 1'b0; bus.new_pc = '0; bus.if_ready_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    //   name     rst stl bf target        fl newpc         rdy  pc            ce pend mis
    cyc("rst1",    1, 0, 0, 32'h0,         0, 32'h0,         1, c_R,           0, 0, 0);
    cyc("rst2",    1, 0, 0, 32'h0,         0, 32'h0,         1, c_R,           0, 0, 0);
    cyc("rel0",    0, 0, 0, 32'h0,         0, 32'h0,         1, c_R,           0, 0, 0);
    cyc("run0",    0, 0, 0, 32'h0,         0, 32'h0,         1, c_R,           1, 0, 0);
    cyc("run1",    0, 0, 0, 32'h0,         0, 32'h0,         1, 32'hBFC00004,  1, 0, 0);
    cyc("stbr",    0, 1, 1, 32'h80000100,  0, 32'h0,         1, 32'hBFC00008,  1, 0, 0);
    cyc("stl2",    0, 1, 0, 32'h0,         0, 32'h0,         1, 32'hBFC00008,  1, 1, 0);
    cyc("strel",   0, 0, 0, 32'h0,         0, 32'h0,         1, 32'hBFC00008,  1, 1, 0);
    cyc("pendld",  0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h80000100,  1, 0, 0);
    cyc("bpcap",   0, 0, 1, 32'h80000100,  0, 32'h0,         0, 32'h80000104,  1, 0, 0);
    cyc("bpnew",   0, 0, 1, 32'h80000200,  0, 32'h0,         1, 32'h80000104,  1, 1, 0);
    cyc("flcap",   0, 1, 1, 32'h80000300,  0, 32'h0,         1, 32'h80000200,  1, 0, 0);
    cyc("flush",   0, 1, 1, 32'h80000400,  1, 32'h80000180,  1, 32'h80000200,  1, 1, 0);
    cyc("flpc",    0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h80000180,  1, 0, 0);
    cyc("wrbr",    0, 0, 1, 32'hFFFFFFF8,  0, 32'h0,         1, 32'h80000184,  1, 0, 0);
    cyc("wr0",     0, 0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFFFFF8,  1, 0, 0);
    cyc("wr1",     0, 0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFFFFFC,  1, 0, 0);
    cyc("wrap",    0, 0, 1, 32'h80000102,  0, 32'h0,         1, 32'h00000000,  1, 0, 0);
    cyc("mis0",    0, 1, 0, 32'h0,         0, 32'h0,         1, c_M,           1, 0, c_MIS);
    cyc("mishold", 0, 0, 0, 32'h0,         0, 32'h0,         1, c_M,           1, 0, c_MIS);
    cyc("misstep", 0, 0, 1, 32'h80001000,  0, 32'h0,         0, c_M + 32'd4,   1, 0, c_MIS);
    cyc("rstmid",  1, 0, 0, 32'h0,         0, 32'h0,         1, c_M + 32'd4,   1, 1, c_MIS);
    cyc("rstign",  0, 1, 1, 32'h80000500,  1, 32'h80000180,  1, c_R,           0, 0, 0);
    cyc("rerun",   0, 0, 0, 32'h0,         0, 32'h0,         1, c_R,           1, 0, 0);
    cyc("rerun1",  0, 0, 0, 32'h0,         0, 32'h0,         1, c_R + 32'd4,   1, 0, 0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_gen.md
# pc_fetch_gen

Parametrised program-counter generator for the IF stage of the pipelined MIPS core. It produces the fetch address and chip-enable for instruction memory and advances by a fixed step. It applies exception flushes and branch redirects, and holds on pipeline stall or on instruction-memory back-pressure. A branch redirect that arrives while the PC cannot advance is captured in a one-entry pending-redirect register, so it is never lost.

## Interface
Parameters:
- ADDR_W, 32: PC / address width in bits.
- RESET_VECTOR, 32'hBFC0_0000: PC value during and immediately after reset (truncated to ADDR_W).
- STEP, 4: sequential increment in bytes.
- STALL_W, 6: width of the stall bus; only bit 0 (IF stage) is used.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  STALL_W  pipeline stall vector; stall[0]=1 holds the PC.
- branch_flag_i  in  1  redirect request from ID, 1 = take branch_target_i.
- branch_target_i  in  ADDR_W  redirect target.
- flush  in  1  exception/eret flush, highest priority.
- new_pc  in  ADDR_W  flush target.
- if_ready_i  in  1  instruction memory accepts the current fetch this cycle.
- pc  out  ADDR_W  registered fetch address.
- ce  out  1  registered instruction-memory chip enable.
- if_req_o  out  1  combinational fetch request = ce & ~stall[0].
- pend_valid_o  out  1  registered; a captured redirect is waiting.
- pc_misalign_o  out  1  registered; pc low bits nonzero (macro-dependent, see Configuration).

## Operation
- States: RESET (ce=0) and RUN (ce=1). rst=1 moves to RESET from any state. The first edge with rst=0 moves to RUN. Reset mid-operation discards any pending redirect.
- In RESET: pc held at RESET_VECTOR; flush, branch and stall are ignored.
- advance = ce & ~stall[0] & if_ready_i.
- Next-pc priority in RUN:
  - 1. flush: pc <= new_pc; pending cleared. Flush wins regardless of stall, ready or branch.
  - 2. advance & branch_flag_i: pc <= branch_target_i; pending cleared. A newer branch overrides an older pending redirect.
  - 3. advance & pend_valid: pc <= pending target; pending cleared.
  - 4. advance: pc <= pc + STEP, modulo 2^ADDR_W (wrap from all-ones region to low addresses, no flag).
  - 5. otherwise: pc holds.
- Pending capture: in RUN with ~flush & ~advance & branch_flag_i, pend_target <= branch_target_i and pend_valid <= 1. A later capture overwrites the earlier one.

## Timing
- Reset values: ce=0, pc=RESET_VECTOR, pend_valid_o=0, pc_misalign_o=0, if_req_o=0.
- ce rises one cycle after rst deasserts. pc stays RESET_VECTOR on that edge, so the first fetch is RESET_VECTOR.
- Redirect latency: one edge. A branch or flush sampled at edge N is visible on pc after edge N.
- Captured redirect appears on pc after the first edge where advance=1, unless a flush or newer branch arrives on that same edge.
- if_req_o is combinational from registered ce and the stall input. It carries no path from if_ready_i.

## Configuration
- PC_MISALIGN_CHK_EN defined:
  - Redirect targets (new_pc, branch, pending) load unmodified.
  - pc_misalign_o is registered alongside pc and equals |pc[1:0]. It stays high for as long as the misaligned pc is held.
- PC_MISALIGN_CHK_EN undefined:
  - Bits [1:0] of every redirect target are forced to 0 before loading.
  - pc_misalign_o is constant 0.
- Sequential stepping is unaffected in both cases.

## Test plan
- Reset release: rst=1 for 3 cycles then 0, if_ready_i=1, no stall.
  - Expect ce=0/pc=BFC00000 during reset.
  - Expect ce=1 with pc=BFC00000, then BFC00004, then BFC00008.
- Stall then branch: stall[0]=1 for 2 cycles with branch_flag_i=1, target=80000100 in the first stall cycle; release.
  - Expect pend_valid_o=1 during stall and pc unchanged.
  - After release, pc=80000100, pend_valid_o=0, then 80000104.
- Back-pressure with a newer branch: pending=80000100 captured, if_ready_i=0. Next cycle if_ready_i=1 with branch_flag_i=1, target=80000200.
  - Expect pc=80000200 and pending cleared.
- Flush priority: stall[0]=1, pend_valid=1, branch_flag_i=1, flush=1, new_pc=80000180 in the same cycle.
  - Expect pc=80000180 and pend_valid_o=0.
- Wrap: pc=FFFFFFFC, advance.
  - Expect pc=00000000 with no flag.
- Misalign: branch to 80000102.
  - With macro defined: pc=80000102 and pc_misalign_o=1.
  - Without macro: pc=80000100 and pc_misalign_o=0.
